// File: rtl/block_puncturer.sv
// Word-stream puncturer: drops words by a periodic keep mask and re-frames survivors.
// Optional PUNCTURER_BYPASS_EN adds i_bypass, which keeps every word of the codeword it is sampled with.
module block_puncturer #(
    parameter int                     WORD_LENGTH = 3,
    parameter int                     PATTERN_LEN = 4,
    parameter logic [PATTERN_LEN-1:0] PATTERN     = 4'b1101
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_valid,
    input  logic [WORD_LENGTH-1:0] i_data,
    input  logic                   i_start_cw,
    input  logic                   i_end_cw,
    output logic                   o_in_ready,
    output logic                   o_valid,
    output logic [WORD_LENGTH-1:0] o_data,
    output logic                   o_start_cw,
    output logic                   o_end_cw,
    output logic                   o_error,
    input  logic                   i_consume
`ifdef PUNCTURER_BYPASS_EN
    ,
    input  logic                   i_bypass
`endif
);

    localparam int PW = (PATTERN_LEN > 1) ? $clog2(PATTERN_LEN) : 1;
    localparam logic [PW-1:0] POS_LAST  = PW'(PATTERN_LEN - 1);
    localparam logic [PW-1:0] POS_FIRST = (PATTERN_LEN > 1) ? PW'(1) : '0;

    typedef enum logic [1:0] {IDLE, RECEIVING, ERROR} state_t;

    state_t                 state_reg, state_next;
    logic [PW-1:0]          pos_reg, pos_next;
    logic [WORD_LENGTH-1:0] h_data_reg, h_data_next;
    logic                   h_start_reg, h_start_next;
    logic                   h_valid_reg, h_valid_next;
    logic                   flush_reg, flush_next;
    logic [WORD_LENGTH-1:0] o_data_reg, o_data_next;
    logic                   o_start_reg, o_start_next;
    logic                   o_end_reg, o_end_next;
    logic                   o_valid_reg, o_valid_next;

    logic o_free;
    logic in_ready;
    logic accept;
    logic keep;
    logic [PW-1:0] pos_inc;

    assign o_free   = !o_valid_reg || i_consume;
    assign in_ready = (state_reg == ERROR) || (o_free && !flush_reg);
    assign accept   = i_valid && in_ready;
    assign pos_inc  = (pos_reg == POS_LAST) ? '0 : pos_reg + PW'(1);

`ifdef PUNCTURER_BYPASS_EN
    logic bypass_reg, bypass_next;
    assign keep = PATTERN[pos_reg] || bypass_reg;
`else
    assign keep = PATTERN[pos_reg];
`endif

    always_comb begin
        state_next   = state_reg;
        pos_next     = pos_reg;
        h_data_next  = h_data_reg;
        h_start_next = h_start_reg;
        h_valid_next = h_valid_reg;
        flush_next   = flush_reg;
        o_data_next  = o_data_reg;
        o_start_next = o_start_reg;
        o_end_next   = o_end_reg;
        o_valid_next = o_valid_reg;
`ifdef PUNCTURER_BYPASS_EN
        bypass_next  = bypass_reg;
`endif

        if (o_valid_reg && i_consume)
            o_valid_next = 1'b0;

        // Flush: the held final word moves to O once O is free.
        if (flush_reg && o_free) begin
            o_data_next  = h_data_reg;
            o_start_next = h_start_reg;
            o_end_next   = 1'b1;
            o_valid_next = 1'b1;
            h_valid_next = 1'b0;
            flush_next   = 1'b0;
        end

        if (accept) begin
            if (i_start_cw && state_reg != RECEIVING) begin
                // Fresh codeword (from IDLE, or leaving ERROR); position 0 is always kept.
                pos_next = POS_FIRST;
`ifdef PUNCTURER_BYPASS_EN
                bypass_next = i_bypass;
`endif
                if (i_end_cw) begin
                    state_next = IDLE;
                    if (o_free) begin
                        o_data_next  = i_data;
                        o_start_next = 1'b1;
                        o_end_next   = 1'b1;
                        o_valid_next = 1'b1;
                    end else begin
                        h_data_next  = i_data;
                        h_start_next = 1'b1;
                        h_valid_next = 1'b1;
                        flush_next   = 1'b1;
                    end
                end else begin
                    h_data_next  = i_data;
                    h_start_next = 1'b1;
                    h_valid_next = 1'b1;
                    state_next   = RECEIVING;
                end
            end else if (state_reg == IDLE || (state_reg == RECEIVING && i_start_cw)) begin
                h_valid_next = 1'b0;
                state_next   = ERROR;
            end else if (state_reg == RECEIVING) begin
                pos_next = pos_inc;
                if (i_end_cw) begin
                    state_next = IDLE;
                    if (keep && h_valid_reg) begin
                        o_data_next  = h_data_reg;
                        o_start_next = h_start_reg;
                        o_end_next   = 1'b0;
                        o_valid_next = 1'b1;
                        h_data_next  = i_data;
                        h_start_next = 1'b0;
                        flush_next   = 1'b1;
                    end else if (keep) begin
                        o_data_next  = i_data;
                        o_start_next = 1'b1;
                        o_end_next   = 1'b1;
                        o_valid_next = 1'b1;
                    end else if (h_valid_reg) begin
                        // Dropped end word: the held kept word becomes the last one.
                        o_data_next  = h_data_reg;
                        o_start_next = h_start_reg;
                        o_end_next   = 1'b1;
                        o_valid_next = 1'b1;
                        h_valid_next = 1'b0;
                    end else begin
                        state_next = ERROR;
                    end
                end else if (keep) begin
                    if (h_valid_reg) begin
                        o_data_next  = h_data_reg;
                        o_start_next = h_start_reg;
                        o_end_next   = 1'b0;
                        o_valid_next = 1'b1;
                    end
                    h_data_next  = i_data;
                    h_start_next = !h_valid_reg;
                    h_valid_next = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            pos_reg     <= '0;
            h_data_reg  <= '0;
            h_start_reg <= 1'b0;
            h_valid_reg <= 1'b0;
            flush_reg   <= 1'b0;
            o_data_reg  <= '0;
            o_start_reg <= 1'b0;
            o_end_reg   <= 1'b0;
            o_valid_reg <= 1'b0;
`ifdef PUNCTURER_BYPASS_EN
            bypass_reg  <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            pos_reg     <= pos_next;
            h_data_reg  <= h_data_next;
            h_start_reg <= h_start_next;
            h_valid_reg <= h_valid_next;
            flush_reg   <= flush_next;
            o_data_reg  <= o_data_next;
            o_start_reg <= o_start_next;
            o_end_reg   <= o_end_next;
            o_valid_reg <= o_valid_next;
`ifdef PUNCTURER_BYPASS_EN
            bypass_reg  <= bypass_next;
`endif
        end
    end

    assign o_in_ready = in_ready;
    assign o_valid    = o_valid_reg;
    assign o_data     = o_data_reg;
    assign o_start_cw = o_start_reg;
    assign o_end_cw   = o_end_reg;
    assign o_error    = (state_reg == ERROR);

endmodule

// File: tb/tb_block_puncturer.sv
// Directed self-checking bench for block_puncturer (default pattern plus a 4'b0001 instance).
module tb_block_puncturer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       i_valid = 1'b0;
    logic [2:0] i_data = '0;
    logic       i_start_cw = 1'b0;
    logic       i_end_cw = 1'b0;
    logic       i_consume = 1'b1;
    logic       o_in_ready, o_valid, o_start_cw, o_end_cw, o_error;
    logic [2:0] o_data;

    logic       p_valid = 1'b0;
    logic [2:0] p_data = '0;
    logic       p_start = 1'b0;
    logic       p_end = 1'b0;
    logic       p_o_in_ready, p_o_valid, p_o_start, p_o_end, p_o_error;
    logic [2:0] p_o_data;

`ifdef PUNCTURER_BYPASS_EN
    logic i_bypass = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    // Output record: {data, start, end}
    logic [4:0] got [$];
    logic [4:0] exp_std [4] = '{5'b001_1_0, 5'b011_0_0, 5'b100_0_0, 5'b101_0_1};

    block_puncturer dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data),
        .i_start_cw(i_start_cw), .i_end_cw(i_end_cw), .o_in_ready(o_in_ready),
        .o_valid(o_valid), .o_data(o_data), .o_start_cw(o_start_cw),
        .o_end_cw(o_end_cw), .o_error(o_error), .i_consume(i_consume)
`ifdef PUNCTURER_BYPASS_EN
        , .i_bypass(i_bypass)
`endif
    );

    block_puncturer #(.WORD_LENGTH(3), .PATTERN_LEN(4), .PATTERN(4'b0001)) dut_p1 (
        .clk(clk), .rst(rst), .i_valid(p_valid), .i_data(p_data),
        .i_start_cw(p_start), .i_end_cw(p_end), .o_in_ready(p_o_in_ready),
        .o_valid(p_o_valid), .o_data(p_o_data), .o_start_cw(p_o_start),
        .o_end_cw(p_o_end), .o_error(p_o_error), .i_consume(1'b1)
`ifdef PUNCTURER_BYPASS_EN
        , .i_bypass(1'b0)
`endif
    );

    always #5 clk = ~clk;

    // i_consume only changes just after a rising edge, so its value here decides the next edge.
    always @(negedge clk)
        if (rst && o_valid && i_consume)
            got.push_back({o_data, o_start_cw, o_end_cw});

    task automatic send_word(input logic [2:0] d, input logic s, input logic e);
        int n = 0;
        @(negedge clk);
        i_valid = 1'b1; i_data = d; i_start_cw = s; i_end_cw = e;
        #1;
        while (!o_in_ready && n < 50) begin
            @(negedge clk); #1; n++;
        end
        if (!o_in_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout word=%0d o_in_ready=%0b required 1", d, o_in_ready);
        end
        @(posedge clk);
        #1;
        i_valid = 1'b0; i_start_cw = 1'b0; i_end_cw = 1'b0;
    endtask

    task automatic send_cw(input int first, input int n);
        for (int k = 0; k < n; k++)
            send_word(3'(first + k), k == 0, k == n - 1);
    endtask

    task automatic drain();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", o_valid); end
        checks++; if (o_data !== 3'd0) begin errors++; $display("FAIL reset_data got=%0d exp=0", o_data); end
        checks++; if ({o_start_cw, o_end_cw} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b exp=00", {o_start_cw, o_end_cw}); end
        checks++; if (o_error !== 1'b0) begin errors++; $display("FAIL reset_error got=%0b exp=0", o_error); end
        checks++; if (o_in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%0b exp=1", o_in_ready); end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        $display("test_reset done");
    endtask

    task automatic test_dropped_end();
        got.delete();
        send_cw(1, 6);
        drain();
        checks++;
        if (got.size() !== 4) begin
            errors++; $display("FAIL drop_end_count got=%0d exp=4", got.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got[i] !== exp_std[i]) begin
                    errors++;
                    $display("FAIL drop_end_word%0d got d=%0d s=%0b e=%0b exp d=%0d s=%0b e=%0b", i,
                             got[i][4:2], got[i][1], got[i][0], exp_std[i][4:2], exp_std[i][1], exp_std[i][0]);
                end
            end
        end
        $display("test_dropped_end: %0d words out", got.size());
    endtask

    task automatic test_flush();
        int low = 0;
        got.delete();
        fork
            begin send_cw(1, 5); drain(); end
            repeat (10) begin @(negedge clk); #2; if (!o_in_ready) low++; end
        join
        checks++; if (low !== 1) begin errors++; $display("FAIL flush_ready_low got=%0d cycles exp=1", low); end
        checks++;
        if (got.size() !== 4) begin
            errors++; $display("FAIL flush_count got=%0d exp=4", got.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got[i] !== exp_std[i]) begin
                    errors++;
                    $display("FAIL flush_word%0d got d=%0d s=%0b e=%0b exp d=%0d s=%0b e=%0b", i,
                             got[i][4:2], got[i][1], got[i][0], exp_std[i][4:2], exp_std[i][1], exp_std[i][0]);
                end
            end
        end
        $display("test_flush: ready low %0d cycle(s)", low);
    endtask

    task automatic test_back_to_back();
        got.delete();
        send_cw(1, 5);
        send_cw(1, 6);
        drain();
        checks++;
        if (got.size() !== 8) begin
            errors++; $display("FAIL b2b_count got=%0d exp=8", got.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (got[i] !== exp_std[i % 4]) begin
                    errors++;
                    $display("FAIL b2b_word%0d got d=%0d s=%0b e=%0b exp d=%0d s=%0b e=%0b", i,
                             got[i][4:2], got[i][1], got[i][0], exp_std[i % 4][4:2], exp_std[i % 4][1], exp_std[i % 4][0]);
                end
            end
        end
        $display("test_back_to_back: %0d words out", got.size());
    endtask

    task automatic test_backpressure();
        got.delete();
        fork
            begin send_cw(1, 6); drain(); drain(); end
            begin
                repeat (3) @(posedge clk);
                #1 i_consume = 1'b0;
                for (int c = 0; c < 3; c++) begin
                    @(negedge clk);
                    checks++;
                    if ({o_valid, o_in_ready, o_data, o_start_cw} !== 6'b1_0_001_1) begin
                        errors++;
                        $display("FAIL bp_stall%0d got valid=%0b ready=%0b d=%0d s=%0b exp valid=1 ready=0 d=1 s=1",
                                 c, o_valid, o_in_ready, o_data, o_start_cw);
                    end
                end
                @(posedge clk);
                #1 i_consume = 1'b1;
            end
        join
        checks++;
        if (got.size() !== 4) begin
            errors++; $display("FAIL bp_count got=%0d exp=4", got.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got[i] !== exp_std[i]) begin
                    errors++;
                    $display("FAIL bp_word%0d got d=%0d s=%0b e=%0b exp d=%0d s=%0b e=%0b", i,
                             got[i][4:2], got[i][1], got[i][0], exp_std[i][4:2], exp_std[i][1], exp_std[i][0]);
                end
            end
        end
        $display("test_backpressure: %0d words out", got.size());
    endtask

    task automatic test_single();
        send_word(3'd7, 1'b1, 1'b1);
        checks++;
        if ({o_valid, o_data, o_start_cw, o_end_cw} !== 6'b1_111_1_1) begin
            errors++;
            $display("FAIL single got valid=%0b d=%0d s=%0b e=%0b exp valid=1 d=7 s=1 e=1",
                     o_valid, o_data, o_start_cw, o_end_cw);
        end
        drain();
        $display("test_single: d=7 checked");
    endtask

    task automatic test_errors();
        // Start inside a codeword
        got.delete();
        send_word(3'd1, 1'b1, 1'b0);
        send_word(3'd2, 1'b1, 1'b0);
        checks++; if (o_error !== 1'b1) begin errors++; $display("FAIL err_restart got=%0b exp=1", o_error); end
        drain();
        checks++; if (got.size() !== 0) begin errors++; $display("FAIL err_h_discard got=%0d words exp=0", got.size()); end
        send_cw(1, 6);
        drain();
        checks++; if (o_error !== 1'b0) begin errors++; $display("FAIL err_recover got=%0b exp=0", o_error); end
        checks++;
        if (got.size() !== 4 || got[3] !== 5'b101_0_1) begin
            errors++; $display("FAIL err_recover_out got count=%0d exp count=4 last d=5 e=1", got.size());
        end
        // Pattern 4'b0001: the lone kept word is retagged as last
        @(negedge clk); p_valid = 1'b1; p_data = 3'd1; p_start = 1'b1; p_end = 1'b0;
        @(negedge clk); p_data = 3'd2; p_start = 1'b0; p_end = 1'b1;
        @(posedge clk); #1;
        p_valid = 1'b0; p_end = 1'b0;
        checks++;
        if ({p_o_valid, p_o_data, p_o_start, p_o_end, p_o_error} !== 7'b1_001_1_1_0) begin
            errors++;
            $display("FAIL p0001 got valid=%0b d=%0d s=%0b e=%0b err=%0b exp valid=1 d=1 s=1 e=1 err=0",
                     p_o_valid, p_o_data, p_o_start, p_o_end, p_o_error);
        end
        // Codeword without a start
        send_word(3'd3, 1'b0, 1'b0);
        checks++; if (o_error !== 1'b1) begin errors++; $display("FAIL err_nostart got=%0b exp=1", o_error); end
        send_word(3'd4, 1'b0, 1'b1);
        checks++; if (o_error !== 1'b1) begin errors++; $display("FAIL err_hold got=%0b exp=1", o_error); end
        send_word(3'd6, 1'b1, 1'b1);
        checks++;
        if ({o_error, o_valid, o_data} !== 5'b0_1_110) begin
            errors++; $display("FAIL err_exit got err=%0b valid=%0b d=%0d exp err=0 valid=1 d=6", o_error, o_valid, o_data);
        end
        drain();
        $display("test_errors done");
    endtask

    task automatic test_reset_midstream();
        i_consume = 1'b0;
        send_word(3'd1, 1'b1, 1'b0);
        send_word(3'd2, 1'b0, 1'b0);
        send_word(3'd3, 1'b0, 1'b0);
        checks++; if ({o_valid, o_data} !== 4'b1_001) begin errors++; $display("FAIL rm_pre got valid=%0b d=%0d exp valid=1 d=1", o_valid, o_data); end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({o_valid, o_data, o_start_cw, o_end_cw, o_error, o_in_ready} !== 8'b0_000_0_0_0_1) begin
            errors++;
            $display("FAIL rm_async got valid=%0b d=%0d s=%0b e=%0b err=%0b ready=%0b exp all 0 ready=1",
                     o_valid, o_data, o_start_cw, o_end_cw, o_error, o_in_ready);
        end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1 i_consume = 1'b1;
        got.delete();
        send_cw(1, 6);
        drain();
        checks++;
        if (got.size() !== 4) begin
            errors++; $display("FAIL rm_count got=%0d exp=4", got.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got[i] !== exp_std[i]) begin
                    errors++;
                    $display("FAIL rm_word%0d got d=%0d s=%0b e=%0b exp d=%0d s=%0b e=%0b", i,
                             got[i][4:2], got[i][1], got[i][0], exp_std[i][4:2], exp_std[i][1], exp_std[i][0]);
                end
            end
        end
        $display("test_reset_midstream: %0d words out", got.size());
    endtask

`ifdef PUNCTURER_BYPASS_EN
    task automatic test_bypass();
        got.delete();
        i_bypass = 1'b1;
        send_cw(1, 6);
        i_bypass = 1'b0;
        drain();
        checks++;
        if (got.size() !== 6 || got[0] !== 5'b001_1_0 || got[5] !== 5'b110_0_1) begin
            errors++; $display("FAIL bypass got count=%0d exp count=6 first d=1 s=1 last d=6 e=1", got.size());
        end
        $display("test_bypass: %0d words out", got.size());
    endtask
`endif

    initial begin
        test_reset();
        test_dropped_end();
        test_flush();
        test_back_to_back();
        test_backpressure();
        test_single();
        test_errors();
        test_reset_midstream();
`ifdef PUNCTURER_BYPASS_EN
        test_bypass();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout reached, simulation did not finish");
        $fatal(1);
    end

endmodule
